// File: rtl/ntt_stage_scheduler.sv
// NTT stage scheduler: walks LOGN stages of B beats each through P butterflies, then drains BF_LAT cycles.
// Latency: first read beat one cycle after start is accepted; done at LOGN*(B+BF_LAT)+1; write strobes trail reads by BF_LAT.
// Backpressure: none; start is honoured only in IDLE. Optional NTT_SCHED_PERF_EN adds a 16-bit perf_cycles busy counter.
module ntt_stage_scheduler #(
    parameter int N      = 2048,
    parameter int P      = 32,
    parameter int LOGN   = 11,
    parameter int LOGP   = 5,
    parameter int BF_LAT = 8,
    localparam int B     = N / (2 * P),
    localparam int AW    = (B > 1) ? $clog2(B) : 1,
    localparam int TW    = LOGN - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [3:0]    stage,
    output logic          bf_valid,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic [TW-1:0] tw_idx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_bank
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [15:0]   perf_cycles
`endif
);

    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_b;
    logic [3:0]    r_stage;
    logic [DW-1:0] r_drn;
    logic          r_busy;
    logic          r_done;
    logic          r_bf_valid;
    logic [TW-1:0] r_tw;

    state_t        w_state_nxt;
    logic [AW-1:0] w_b_nxt;
    logic [3:0]    w_stage_nxt;
    logic [DW-1:0] w_drn_nxt;
    logic          w_accept;
    logic [3:0]    w_shift;
    logic [TW-1:0] w_tw_base;
    logic [TW-1:0] w_tw_nxt;

    logic [BF_LAT-1:0] r_dl_vld;
    logic [BF_LAT-1:0] r_dl_bank;
    logic [AW-1:0]     r_dl_addr [BF_LAT];

    // Next-state, counter updates and the twiddle index for the upcoming beat
    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_stage_nxt = r_stage;
        w_drn_nxt   = r_drn;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                    w_stage_nxt = 4'd0;
                    w_b_nxt     = '0;
                    w_accept    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_b == AW'(B - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_drn_nxt   = '0;
                    w_b_nxt     = '0;
                end else begin
                    w_b_nxt = r_b + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drn == DW'(BF_LAT - 1)) begin
                    if (r_stage == 4'(LOGN - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_stage_nxt = r_stage + 4'd1;
                        w_b_nxt     = '0;
                    end
                end else begin
                    w_drn_nxt = r_drn + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stage_nxt = 4'd0;
            end
        endcase
        // b*P spans exactly TW bits, so the shift never loses high-order bits.
        w_shift   = 4'(LOGN - 1) - w_stage_nxt;
        w_tw_base = TW'({w_b_nxt, {LOGP{1'b0}}});
        w_tw_nxt  = w_tw_base >> w_shift;
    end

    // State, counters and registered read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_b        <= '0;
            r_stage    <= 4'd0;
            r_drn      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bf_valid <= 1'b0;
            r_tw       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_b        <= w_b_nxt;
            r_stage    <= w_stage_nxt;
            r_drn      <= w_drn_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_bf_valid <= (w_state_nxt == S_ISSUE);
            r_tw       <= w_tw_nxt;
        end
    end

    // Write-side delay line: read beat, address and flipped bank re-emerge BF_LAT cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld  <= '0;
            r_dl_bank <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                r_dl_addr[i] <= '0;
            end
        end else begin
            r_dl_vld[0]  <= r_bf_valid;
            r_dl_bank[0] <= ~r_stage[0];
            r_dl_addr[0] <= r_b;
            for (int i = 1; i < BF_LAT; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_bank[i] <= r_dl_bank[i-1];
                r_dl_addr[i] <= r_dl_addr[i-1];
            end
        end
    end

`ifdef NTT_SCHED_PERF_EN
    logic [15:0] r_perf;

    // Busy-cycle counter: restarts at 1 on the accepting edge, freezes once the frame ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= 16'd0;
        end else if (w_accept) begin
            r_perf <= 16'd1;
        end else if (w_state_nxt != S_IDLE) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign stage    = r_stage;
    assign bf_valid = r_bf_valid;
    assign rd_addr  = r_b;
    assign rd_bank  = r_stage[0];
    assign tw_idx   = r_tw;
    assign wr_en    = r_dl_vld[BF_LAT-1];
    assign wr_addr  = r_dl_addr[BF_LAT-1];
    assign wr_bank  = r_dl_bank[BF_LAT-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler at default parameters (N=2048, P=32, BF_LAT=8).
// Frame timing is predicted in closed form: stage s issues in cycles 1+40s .. 40s+32, done in 441.
// Define NTT_SCHED_PERF_EN to also check perf_cycles.
module tb_ntt_stage_scheduler;

    localparam int B      = 32;
    localparam int L      = 8;
    localparam int SL     = B + L;
    localparam int T_DONE = 441;
    localparam int NWR    = 352;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  stage;
    logic        bf_valid;
    logic [4:0]  rd_addr;
    logic        rd_bank;
    logic [9:0]  tw_idx;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        wr_bank;
`ifdef NTT_SCHED_PERF_EN
    logic [15:0] perf_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ntt_stage_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .stage       (stage),
        .bf_valid    (bf_valid),
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .tw_idx      (tw_idx),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_bank     (wr_bank)
`ifdef NTT_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit f_vld(input int c);
        if (c < 1 || c > T_DONE - 1) return 1'b0;
        return ((c - 1) % SL) < B;
    endfunction

    // One full frame from a single-cycle start pulse, checked cycle by cycle
    task automatic run_frame(input string nm);
        int nwr;
        nwr = 0;
        start = 1'b1;
        for (int c = 1; c <= T_DONE + 4; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            chk($sformatf("%s bf_valid c%0d", nm, c), 32'(bf_valid), 32'(f_vld(c)));
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'(c <= T_DONE));
            chk($sformatf("%s done c%0d", nm, c), 32'(done), 32'(c == T_DONE));
            chk($sformatf("%s wr_en c%0d", nm, c), 32'(wr_en), 32'(f_vld(c - L)));
            if (f_vld(c)) begin
                chk($sformatf("%s rd_addr c%0d", nm, c), 32'(rd_addr), 32'((c - 1) % SL));
                chk($sformatf("%s stage c%0d", nm, c), 32'(stage), 32'((c - 1) / SL));
                chk($sformatf("%s rd_bank c%0d", nm, c), 32'(rd_bank), 32'(((c - 1) / SL) % 2));
                if (c <= B) chk($sformatf("%s tw_stage0 c%0d", nm, c), 32'(tw_idx), 32'd0);
            end
            if (f_vld(c - L)) begin
                nwr++;
                chk($sformatf("%s wr_addr c%0d", nm, c), 32'(wr_addr), 32'((c - L - 1) % SL));
                chk($sformatf("%s wr_bank c%0d", nm, c), 32'(wr_bank), 32'(1 - ((c - L - 1) / SL) % 2));
            end
            if (c == 41)  chk($sformatf("%s stage_at_41", nm), 32'(stage), 32'd1);
            // stage 10, b=3: 96 >> 0
            if (c == 404) chk($sformatf("%s tw_s10_b3", nm), 32'(tw_idx), 32'd96);
            // stage 5, b=17: 544 >> 5
            if (c == 218) chk($sformatf("%s tw_s5_b17", nm), 32'(tw_idx), 32'd17);
            // stage 9, b=5: 160 >> 1
            if (c == 366) chk($sformatf("%s tw_s9_b5", nm), 32'(tw_idx), 32'd80);
            // stage 1, b=31: 992 >> 9
            if (c == 72)  chk($sformatf("%s tw_s1_b31", nm), 32'(tw_idx), 32'd1);
`ifdef NTT_SCHED_PERF_EN
            if (c == T_DONE)     chk($sformatf("%s perf_done", nm), 32'(perf_cycles), 32'd441);
            if (c == T_DONE + 4) chk($sformatf("%s perf_hold", nm), 32'(perf_cycles), 32'd441);
`endif
        end
        chk($sformatf("%s write_count", nm), 32'(nwr), 32'(NWR));
    endtask

    initial begin
        int ndone;
        int d0;
        int d1;
        rst_n = 1'b1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst stage", 32'(stage), 32'd0);
        chk("rst bf_valid", 32'(bf_valid), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst tw_idx", 32'(tw_idx), 32'd0);
`ifdef NTT_SCHED_PERF_EN
        chk("rst perf", 32'(perf_cycles), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle busy", 32'(busy), 32'd0);

        run_frame("f1");

        // Mid-frame asynchronous reset at cycle 200 (stage 4, last drain cycle)
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        chk("pre_rst stage", 32'(stage), 32'd4);
        chk("pre_rst wr_en", 32'(wr_en), 32'd1);
        chk("pre_rst wr_addr", 32'(wr_addr), 32'd31);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy), 32'd0);
        chk("mid_rst done", 32'(done), 32'd0);
        chk("mid_rst stage", 32'(stage), 32'd0);
        chk("mid_rst bf_valid", 32'(bf_valid), 32'd0);
        chk("mid_rst rd_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst rd_bank", 32'(rd_bank), 32'd0);
        chk("mid_rst tw_idx", 32'(tw_idx), 32'd0);
        chk("mid_rst wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst wr_bank", 32'(wr_bank), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("post_rst wr_en %0d", c), 32'(wr_en), 32'd0);
            chk($sformatf("post_rst busy %0d", c), 32'(busy), 32'd0);
        end

        run_frame("f2");

        // start held high for 600 cycles: exactly two back-to-back frames
        ndone = 0;
        d0 = -1;
        d1 = -1;
        start = 1'b1;
        for (int c = 1; c <= 900; c++) begin
            tick();
            if (c == 600) start = 1'b0;
            if (done) begin
                if (ndone == 0) d0 = c;
                else if (ndone == 1) d1 = c;
                ndone++;
            end
            if (c == 442) chk("held busy_idle_442", 32'(busy), 32'd0);
            if (c == 443) chk("held busy_443", 32'(busy), 32'd1);
`ifdef NTT_SCHED_PERF_EN
            if (c == 442) chk("held perf_hold_442", 32'(perf_cycles), 32'd441);
            if (c == 883) chk("held perf_883", 32'(perf_cycles), 32'd441);
`endif
        end
        chk("held done_count", 32'(ndone), 32'd2);
        chk("held done_first", 32'(d0), 32'd441);
        chk("held done_second", 32'(d1), 32'd883);
        chk("held final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
